instr_packer: RTL and testbench

Streaming RV32I instruction encoder and loader. It accepts decoded instruction fields (format, opcode, funct, registers, full-width immediate) over a valid/ready input. It checks that the immediate is legal for the chosen format and packs the fields into a 32-bit instruction word. Each legal word goes out as a memory write at an auto-incrementing byte address. The block feeds the instruction-memory loader and testbench program builders. Its output must round-trip exactly through the core's immediate sign-extension for the I, S, B and J formats.

---
 rtl/instr_packer_if.sv | 38 +++
 rtl/instr_packer.sv | 97 +++++++++
 tb/tb_instr_packer.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_packer_if.sv
// instr_packer_if: control, input-field stream, output-word stream and status of the instruction packer
interface instr_packer_if #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
);
  logic               start;
  logic [A_WIDTH-1:0] base_addr;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         in_fmt;
  logic [6:0]         in_opcode;
  logic [2:0]         in_funct3;
  logic [6:0]         in_funct7;
  logic [4:0]         in_rd;
  logic [4:0]         in_rs1;
  logic [4:0]         in_rs2;
  logic [D_WIDTH-1:0] in_imm;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic [A_WIDTH-1:0] out_addr;
  logic [D_WIDTH-1:0] out_data;
  logic               err;
  logic [1:0]         err_code;
  logic [A_WIDTH-1:0] word_count;
  logic               busy;
  logic               done;
  modport master (
    output start, base_addr, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
    input  in_ready, out_valid, out_addr, out_data, err, err_code, word_count, busy, done
  );
  modport slave (
    input  start, base_addr, in_valid, in_fmt, in_opcode, in_funct3, in_funct7,
           in_rd, in_rs1, in_rs2, in_imm, in_last, out_ready,
    output in_ready, out_valid, out_addr, out_data, err, err_code, word_count, busy, done
  );
endinterface

// File: rtl/instr_packer.sv
// instr_packer: validates RV32I instruction fields and streams packed words to auto-incrementing addresses
module instr_packer #(
  parameter int A_WIDTH = 32,
  parameter int D_WIDTH = 32
) (
  input logic           clk,
  input logic           rst_n,
  instr_packer_if.slave bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOAD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;
  logic [1:0]                r_state;
  logic                      r_out_valid;
  logic [A_WIDTH-1:0]        r_out_addr;
  logic [D_WIDTH-1:0]        r_out_data;
  logic [A_WIDTH-1:0]        r_addr;
  logic [A_WIDTH-1:0]        r_cnt;
  logic                      r_err;
  logic [1:0]                r_err_code;
  logic                      w_take;
  logic                      w_acc;
  logic                      w_start;
  logic                      w_mis;
  logic                      w_rng;
  logic [1:0]                w_code;
  logic signed [D_WIDTH-1:0] w_imm;
  logic [D_WIDTH-1:0]        w_word;
  logic [2:0]                w_fmt;
  assign w_fmt    = bus.in_fmt;
  assign w_imm    = $signed(bus.in_imm);
  assign w_take   = r_out_valid && bus.out_ready;
  assign bus.in_ready = (r_state == LOAD) && (!r_out_valid || bus.out_ready);
  assign w_acc    = bus.in_valid && bus.in_ready;
  assign w_start  = bus.start && (r_state == IDLE || r_state == DONE);
  // B/J offsets must be halfword aligned; U immediates carry only the upper 20 bits
  assign w_mis = ((w_fmt == 3'd3 || w_fmt == 3'd5) && bus.in_imm[0]) ||
                 (w_fmt == 3'd4 && |bus.in_imm[11:0]);
  assign w_rng = (w_fmt == 3'd1 || w_fmt == 3'd2) ? (w_imm < -2048 || w_imm > 2047) :
                 (w_fmt == 3'd3) ? (w_imm < -4096 || w_imm > 4094) :
                 (w_fmt == 3'd5) ? (w_imm < -1048576 || w_imm > 1048574) : 1'b0;
  assign w_code = (w_fmt > 3'd5) ? 2'b11 : w_mis ? 2'b10 : w_rng ? 2'b01 : 2'b00;
  // Scatter the immediate bits into the slots each format reserves for them
  always_comb begin
    w_word = (w_fmt == 3'd0) ? {bus.in_funct7, bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
             (w_fmt == 3'd1) ? {bus.in_imm[11:0], bus.in_rs1, bus.in_funct3, bus.in_rd, bus.in_opcode} :
             (w_fmt == 3'd2) ? {bus.in_imm[11:5], bus.in_rs2, bus.in_rs1, bus.in_funct3, bus.in_imm[4:0], bus.in_opcode} :
             (w_fmt == 3'd3) ? {bus.in_imm[12], bus.in_imm[10:5], bus.in_rs2, bus.in_rs1, bus.in_funct3,
                                bus.in_imm[4:1], bus.in_imm[11], bus.in_opcode} :
             (w_fmt == 3'd4) ? {bus.in_imm[31:12], bus.in_rd, bus.in_opcode} :
                               {bus.in_imm[20], bus.in_imm[10:1], bus.in_imm[11], bus.in_imm[19:12], bus.in_rd, bus.in_opcode};
  end
  // Program sequencing: load items until the last one is consumed, then wait for the final word to leave
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else if (w_start) r_state <= LOAD;
    else if (r_state == LOAD && w_acc && bus.in_last) r_state <= DRAIN;
    else if (r_state == DRAIN && (!r_out_valid || w_take)) r_state <= DONE;
  end
  // Output register, write address, word counter and error reporting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
      r_addr      <= '0;
      r_cnt       <= '0;
      r_err       <= 1'b0;
      r_err_code  <= 2'b00;
    end else begin
      r_err <= w_acc && (w_code != 2'b00);
      if (w_start) begin
        r_addr     <= {bus.base_addr[A_WIDTH-1:2], 2'b00};
        r_cnt      <= '0;
        r_err_code <= 2'b00;
      end
      if (w_acc && w_code != 2'b00) r_err_code <= w_code;
      if (w_take) r_out_valid <= 1'b0;
      if (w_acc && w_code == 2'b00) begin
        r_out_valid <= 1'b1;
        r_out_addr  <= r_addr;
        r_out_data  <= w_word;
        r_addr      <= r_addr + A_WIDTH'(4);
        r_cnt       <= r_cnt + A_WIDTH'(1);
      end
    end
  end
  assign bus.out_valid  = r_out_valid;
  assign bus.out_addr   = r_out_addr;
  assign bus.out_data   = r_out_data;
  assign bus.err        = r_err;
  assign bus.err_code   = r_err_code;
  assign bus.word_count = r_cnt;
  assign bus.busy       = (r_state == LOAD) || (r_state == DRAIN);
  assign bus.done       = (r_state == DONE);
endmodule

// File: tb/tb_instr_packer.sv
// tb_instr_packer: directed and randomized checks of instr_packer against a queue-based reference model
module tb_instr_packer;
  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } item_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  fmt;
    logic [31:0] imm;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   ready_mode = 0;
  exp_t exp_q[$];
  logic [31:0] m_addr = '0;
  logic [31:0] m_cnt = '0;
  logic        held = 1'b0;
  logic [31:0] h_addr, h_data;
  instr_packer_if #(.A_WIDTH(32), .D_WIDTH(32)) bus ();
  instr_packer #(.A_WIDTH(32), .D_WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic item_t mk(input int fmt, op, f3, f7, rd, rs1, rs2, input logic [31:0] imm, input bit last);
    item_t t;
    t.fmt = 3'(fmt); t.op = 7'(op); t.f3 = 3'(f3); t.f7 = 7'(f7);
    t.rd = 5'(rd); t.rs1 = 5'(rs1); t.rs2 = 5'(rs2); t.imm = imm; t.last = last;
    return t;
  endfunction
  function automatic int legal_code(input item_t t);
    int v;
    v = $signed(t.imm);
    if (t.fmt > 5) return 3;
    case (t.fmt)
      1, 2: return (v < -2048 || v > 2047) ? 1 : 0;
      3: return t.imm[0] ? 2 : (v < -4096 || v > 4094) ? 1 : 0;
      5: return t.imm[0] ? 2 : (v < -1048576 || v > 1048574) ? 1 : 0;
      4: return (t.imm & 32'hFFF) != 0 ? 2 : 0;
      default: return 0;
    endcase
  endfunction
  function automatic logic [31:0] encode(input item_t t);
    logic [31:0] i, op, rd, rs1, rs2, f3;
    i = t.imm; op = 32'(t.op); rd = 32'(t.rd) << 7; rs1 = 32'(t.rs1) << 15;
    rs2 = 32'(t.rs2) << 20; f3 = 32'(t.f3) << 12;
    case (t.fmt)
      0: return (32'(t.f7) << 25) | rs2 | rs1 | f3 | rd | op;
      1: return ((i & 32'hFFF) << 20) | rs1 | f3 | rd | op;
      2: return (((i >> 5) & 32'h7F) << 25) | rs2 | rs1 | f3 | ((i & 32'h1F) << 7) | op;
      3: return (((i >> 12) & 1) << 31) | (((i >> 5) & 32'h3F) << 25) | rs2 | rs1 | f3 |
                (((i >> 1) & 32'hF) << 8) | (((i >> 11) & 1) << 7) | op;
      4: return (i & 32'hFFFFF000) | rd | op;
      default: return (((i >> 20) & 1) << 31) | (((i >> 1) & 32'h3FF) << 21) |
                      (((i >> 11) & 1) << 20) | (((i >> 12) & 32'hFF) << 12) | rd | op;
    endcase
  endfunction
  function automatic logic [31:0] decode_imm(input logic [2:0] fmt, input logic [31:0] d);
    case (fmt)
      1: return {{20{d[31]}}, d[31:20]};
      2: return {{20{d[31]}}, d[31:25], d[11:7]};
      3: return {{19{d[31]}}, d[31], d[7], d[30:25], d[11:8], 1'b0};
      4: return {d[31:12], 12'b0};
      default: return {{11{d[31]}}, d[31], d[19:12], d[20], d[30:21], 1'b0};
    endcase
  endfunction
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom % 2);
    end
  end
  always @(negedge clk) begin
    if (!rst_n) held = 1'b0;
    else begin
      if (held && bus.out_valid) begin
        chk("hold_addr", bus.out_addr, h_addr);
        chk("hold_data", bus.out_data, h_data);
      end
      held = bus.out_valid && !bus.out_ready;
      h_addr = bus.out_addr;
      h_data = bus.out_data;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) chk("extra_word", 32'(exp_q.size()), 32'd1);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("out_addr", bus.out_addr, e.addr);
          chk("out_data", bus.out_data, e.data);
          if (e.fmt != 3'd0) chk("roundtrip_imm", decode_imm(e.fmt, bus.out_data), e.imm);
        end
      end
    end
  end
  task automatic do_start(input logic [31:0] base);
    bus.start = 1'b1;
    bus.base_addr = base;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    m_addr = base & 32'hFFFFFFFC;
    m_cnt = '0;
  endtask
  task automatic send(input item_t t);
    bit got;
    int c;
    bus.in_fmt = t.fmt; bus.in_opcode = t.op; bus.in_funct3 = t.f3; bus.in_funct7 = t.f7;
    bus.in_rd = t.rd; bus.in_rs1 = t.rs1; bus.in_rs2 = t.rs2; bus.in_imm = t.imm;
    bus.in_last = t.last; bus.in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (bus.in_ready) got = 1;
    end
    if (!got) begin
      chk("accept_timeout", 32'(got), 32'd1);
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last = 1'b0;
    c = legal_code(t);
    if (c == 0) begin
      exp_q.push_back('{m_addr, encode(t), t.fmt, t.imm});
      m_addr += 4;
      m_cnt += 1;
      chk("out_valid_lat", 32'(bus.out_valid), 32'd1);
      chk("no_err", 32'(bus.err), 32'd0);
    end else begin
      chk("err_pulse", 32'(bus.err), 32'd1);
      chk("err_code", 32'(bus.err_code), 32'(c));
    end
  endtask
  task automatic wait_done();
    bit d;
    d = 0;
    for (int i = 0; i < 500 && !d; i++) begin
      @(negedge clk);
      d = bus.done;
    end
    chk("done_reached", 32'(d), 32'd1);
    chk("busy_after_done", 32'(bus.busy), 32'd0);
    chk("word_count", bus.word_count, m_cnt);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_err"}, 32'(bus.err), 32'd0);
    chk({tag, "_err_code"}, 32'(bus.err_code), 32'd0);
    chk({tag, "_word_count"}, bus.word_count, 32'd0);
    chk({tag, "_out_addr"}, bus.out_addr, 32'd0);
    chk({tag, "_out_data"}, bus.out_data, 32'd0);
    chk({tag, "_done"}, 32'(bus.done), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask
  function automatic item_t rand_item(input bit last);
    item_t t;
    int f;
    f = ($urandom % 10 == 0) ? 6 + int'($urandom % 2) : int'($urandom % 6);
    t = mk(f, $urandom % 128, $urandom % 8, $urandom % 128, $urandom % 32, $urandom % 32, $urandom % 32, $urandom, last);
    if ($urandom % 6 != 0) begin
      case (f)
        1, 2: t.imm = 32'(int'($urandom % 4096) - 2048);
        3: t.imm = 32'((int'($urandom % 4096) - 2048) * 2);
        4: t.imm = $urandom & 32'hFFFFF000;
        5: t.imm = 32'((int'($urandom % 1048576) - 524288) * 2);
        default: ;
      endcase
    end
    return t;
  endfunction
  initial begin
    item_t t;
    bus.start = 0; bus.base_addr = 0; bus.in_valid = 0; bus.in_fmt = 0; bus.in_opcode = 0;
    bus.in_funct3 = 0; bus.in_funct7 = 0; bus.in_rd = 0; bus.in_rs1 = 0; bus.in_rs2 = 0;
    bus.in_imm = 0; bus.in_last = 0;
    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ready_mode = 0;
    do_start(32'h0);
    send(mk(1, 'h13, 0, 0, 1, 0, 0, 32'd5, 0));
    chk("tp1_data", bus.out_data, 32'h00500093);
    chk("tp1_addr", bus.out_addr, 32'h0);
    chk("tp1_count", bus.word_count, 32'd1);
    send(mk(3, 'h63, 1, 0, 0, 1, 2, -32'sd8, 0));
    chk("tp2_bne", bus.out_data, 32'hFE209CE3);
    send(mk(5, 'h6F, 0, 0, 1, 0, 0, 32'd2048, 0));
    chk("tp2_jal", bus.out_data, 32'h001000EF);
    chk("tp2_jal_addr", bus.out_addr, 32'h8);
    send(mk(1, 'h13, 0, 0, 1, 0, 0, 32'd2048, 0));
    send(mk(3, 'h63, 1, 0, 0, 1, 2, 32'd3, 0));
    send(mk(7, 'h13, 0, 0, 1, 0, 0, 32'd0, 0));
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(bus.err), 32'd0);
    chk("err_code_hold", 32'(bus.err_code), 32'd3);
    send(mk(2, 'h23, 2, 0, 0, 1, 2, 32'd12, 1));
    chk("tp3_sw", bus.out_data, 32'h0020A623);
    chk("tp3_sw_addr", bus.out_addr, 32'hC);
    wait_done();
    ready_mode = 1;
    do_start(32'h103);
    send(mk(0, 'h33, 0, 'h20, 3, 4, 5, 32'd0, 0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    end
    ready_mode = 0;
    send(mk(4, 'h37, 0, 0, 7, 0, 0, 32'h12345000, 0));
    send(mk(1, 'h13, 0, 0, 2, 2, 0, -32'sd2048, 1));
    wait_done();
    do_start(32'hFFFFFFFC);
    send(mk(1, 'h13, 0, 0, 1, 0, 0, 32'd2047, 0));
    send(mk(3, 'h63, 0, 0, 0, 1, 1, 32'd4094, 1));
    wait_done();
    ready_mode = 1;
    do_start(32'h200);
    send(mk(5, 'h6F, 0, 0, 1, 0, 0, -32'sd1048576, 1));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("drain_busy", 32'(bus.busy), 32'd1);
      chk("drain_done", 32'(bus.done), 32'd0);
    end
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.base_addr = 32'h500;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("drain_start_busy", 32'(bus.busy), 32'd1);
    chk("drain_start_count", bus.word_count, 32'd1);
    chk("drain_start_addr", bus.out_addr, 32'h200);
    ready_mode = 0;
    wait_done();
    ready_mode = 2;
    for (int p = 0; p < 4; p++) begin
      do_start($urandom);
      for (int n = 0; n < 25; n++) begin
        repeat ($urandom % 3) begin
          @(posedge clk);
          #1;
        end
        t = rand_item(n == 24);
        send(t);
      end
      wait_done();
    end
    ready_mode = 1;
    do_start(32'h40);
    send(mk(1, 'h13, 0, 0, 1, 0, 0, 32'd1, 0));
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    exp_q.delete();
    check_zero("midreset");
    rst_n = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
